seg_scan8: RTL and testbench
============================

// Module: seg_scan8
// PURPOSE
//  Display driver downstream of the key-entry stage. Multiplexes the 32-bit
//  8-digit BCD word NUMBER onto the board's 8-digit common-anode 7-segment display.
//  Inter-digit blanking prevents ghosting. Optionally blinks the half currently
//  being edited (edit_sel comes from the key stage's mode flag).
// PARAMETERS
//  SCAN_DIV   100000      clk cycles per digit slot (1 ms at 100 MHz, 8 ms frame)
//  BLANK_CYC  1000        cycles per slot with all anodes off; 1 <= BLANK_CYC < SCAN_DIV
//  BLINK_DIV  25000000    cycles per blink half-period (250 ms)
// PORTS
//  clk100mhz  in   1   system clock, 100 MHz
//  rst_n      in   1   asynchronous, active-low reset
//  NUMBER     in   32  digit k = NUMBER[4k+3:4k], k=0..7
//  dp_in      in   8   dp_in[k]=1 lights the decimal point of digit k
//  edit_sel   in   1   0: digits 7..4 are edited; 1: digits 3..0 are edited
//  blink_en   in   1   1: blink the edited half
//  an         out  8   anode enables, active-low, an[k] <-> digit k
//  seg        out  7   {g,f,e,d,c,b,a}, active-low
//  dp         out  1   decimal point, active-low
// BEHAVIOUR
//  - Reset (async assert, sync release): an=8'hFF, seg=7'h7F, dp=1; state=BLANK;
//    idx=7; slot/blink counters=0; blink_phase=1 (visible).
//  - FSM, two states:
//    - BLANK: an=8'hFF, seg=7'h7F, dp=1 for BLANK_CYC cycles.
//      On exit: idx <= idx+1 (7 wraps to 0). Latch nib <= NUMBER[4*idx'+3 -: 4]
//      and dpl <= dp_in[idx'] (idx' = new index). Go to SHOW.
//    - SHOW: for SCAN_DIV-BLANK_CYC cycles: an = ~(8'b1<<idx),
//      seg = decode(nib), dp = ~dpl. Then go to BLANK.
//    - So digit 0 is first shown BLANK_CYC cycles after reset release.
//  - All outputs are registered, with 1 cycle latency from state/counter to pins.
//    NUMBER/dp_in changes during SHOW appear only at that digit's next slot.
//  - Decode: 0..9 use the standard glyphs (0 = 7'h40, 1 = 7'h79, 8 = 7'h00).
//    Nibbles A..F show a dash (7'h3F). No leading-zero suppression.
//  - Blink:
//    - blink_en=0: counter held at 0, blink_phase=1.
//    - blink_en=1: counter runs; blink_phase toggles when the counter reaches
//      BLINK_DIV-1 (counter then wraps to 0).
//    - The first dark half therefore begins BLINK_DIV cycles after blink_en rises.
//  - Blanked digit: when blink_en & ~blink_phase and idx is in the edited half,
//    SHOW drives an=8'hFF, seg=7'h7F, dp=1. Slot timing is unchanged.
//  - edit_sel is sampled every cycle. A toggle mid-slot takes effect on the next cycle.
//  - Reset asserted mid-slot: outputs go to reset values immediately (async).
//  - Counter widths come from $clog2 of the parameters. No overflow beyond
//    the terminal count.
// STRUCTURE
//  - seg_pkg: SEG_BLANK=7'h7F, SEG_DASH=7'h3F, state encoding
//    (ST_BLANK=1'b0, ST_SHOW=1'b1), function seg7_of(bcd) with the glyph table.
//  - Sub-module bcd_to_seg7: combinational nibble -> seg, wraps seg7_of.
//    Instantiated once and fed from nib.
//  - Top holds the FSM, slot counter, idx, blink counter and output registers.
// TESTING  (bench params SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=40)
//  1 Reset: hold rst_n=0 with NUMBER=32'h87654321 -> an=FF, seg=7F, dp=1.
//    Release -> 2 cycles dark, then an=FE, seg=7'h79 ('1') for 6 cycles.
//  2 Scan order: run one 64-cycle frame -> an steps FE,FD,...,7F.
//    seg shows 1..8. Digit 7 wraps to digit 0. Each digit has exactly 2 dark cycles.
//  3 Glyphs: NUMBER=32'hFA98_7650 -> digit 0 = 7'h40, digits 6,7 = 7'h3F (dash).
//    dp_in=8'h01 -> dp=0 only while an=FE.
//  4 Mid-slot update: change NUMBER[3:0] 1->9 during digit 0's SHOW.
//    -> seg stays '1' until the next frame's digit-0 slot shows 7'h10.
//  5 Blink: blink_en=1, edit_sel=0.
//    -> digits 4..7 dark (an=FF) for 40 cycles, lit for the next 40, and so on.
//    -> digits 0..3 are never dark. Flip edit_sel=1 -> digits 0..3 blink instead.
//  6 Async reset mid-SHOW: rst_n=0 at cycle 3 of digit 5's slot.
//    -> an=FF the same cycle. Release -> restart at digit 0 with blink_phase=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and the 7-segment glyph table for the digit scanner.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles render as a dash.
    function automatic logic [6:0] seg7_of(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg7_of = 7'h40;
            4'd1:    seg7_of = 7'h79;
            4'd2:    seg7_of = 7'h24;
            4'd3:    seg7_of = 7'h30;
            4'd4:    seg7_of = 7'h19;
            4'd5:    seg7_of = 7'h12;
            4'd6:    seg7_of = 7'h02;
            4'd7:    seg7_of = 7'h78;
            4'd8:    seg7_of = 7'h00;
            4'd9:    seg7_of = 7'h10;
            default: seg7_of = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = seg7_of(nib);

endmodule

// File: rtl/seg_scan8.sv
// 8-digit common-anode 7-segment scanner with inter-digit blanking and
// optional blinking of the half being edited.
module seg_scan8
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk100mhz,
    input  logic        rst_n,
    input  logic [31:0] NUMBER,
    input  logic [7:0]  dp_in,
    input  logic        edit_sel,
    input  logic        blink_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned SHOW_CYC = SCAN_DIV - BLANK_CYC;
    localparam int unsigned SW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW       = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
    localparam logic [SW-1:0] SHOW_LAST  = SW'(SHOW_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_e        state;
    logic [SW-1:0] slot_cnt;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic          dpl;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [2:0]    idx_nx;
    logic [6:0]    seg_dec;
    logic          hide;

    bcd_to_seg7 u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    assign idx_nx = idx + 3'd1;
    // idx[2] set means upper half; edit_sel=0 edits the upper half.
    assign hide   = blink_en & ~blink_phase & (idx[2] ^ edit_sel);

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BLANK;
            slot_cnt <= '0;
            idx      <= 3'd7;
            nib      <= 4'h0;
            dpl      <= 1'b0;
            an       <= 8'hFF;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            unique case (state)
                ST_BLANK: begin
                    an  <= 8'hFF;
                    seg <= SEG_BLANK;
                    dp  <= 1'b1;
                    if (slot_cnt == BLANK_LAST) begin
                        slot_cnt <= '0;
                        idx      <= idx_nx;
                        nib      <= NUMBER[{idx_nx, 2'b00} +: 4];
                        dpl      <= dp_in[idx_nx];
                        state    <= ST_SHOW;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (hide) begin
                        an  <= 8'hFF;
                        seg <= SEG_BLANK;
                        dp  <= 1'b1;
                    end else begin
                        an  <= ~(8'b1 << idx);
                        seg <= seg_dec;
                        dp  <= ~dpl;
                    end
                    if (slot_cnt == SHOW_LAST) begin
                        slot_cnt <= '0;
                        state    <= ST_BLANK;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan8.sv
// Directed bench for seg_scan8 with a short scan/blink period.
module tb_seg_scan8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] NUMBER;
    logic [7:0]  dp_in;
    logic        edit_sel;
    logic        blink_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [31:0] exp_num;
    logic [7:0]  exp_dpin;
    bit          exp_blink;
    bit          exp_esel;

    always #5 clk = ~clk;

    seg_scan8 #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .BLINK_DIV (40)
    ) dut (
        .clk100mhz (clk),
        .rst_n     (rst_n),
        .NUMBER    (NUMBER),
        .dp_in     (dp_in),
        .edit_sel  (edit_sel),
        .blink_en  (blink_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
        total++;
        assert (got === expv)
        else begin
            bad++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, got, expv);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"}, {8'h00, an}, 16'h00FF);
        check({tag, "_seg"}, {9'h000, seg}, 16'h007F);
        check({tag, "_dp"}, {15'h0000, dp}, 16'h0001);
    endtask

    // Output after the n-th edge since reset release: 8-cycle slots, first 2 dark.
    task automatic check_model(input string tag);
        int p, d;
        bit lit, phase, edited;
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        p      = (n - 1) % 8;
        d      = ((n - 1) / 8) % 8;
        lit    = (p >= 2);
        phase  = !exp_blink || ((((n - 1) / 40) % 2) == 0);
        edited = exp_esel ? (d < 4) : (d >= 4);
        if (lit && !(exp_blink && !phase && edited)) begin
            ea = ~(8'b1 << d);
            es = glyph(exp_num[4*d +: 4]);
            ed = ~exp_dpin[d];
        end else begin
            ea = 8'hFF;
            es = 7'h7F;
            ed = 1'b1;
        end
        check({tag, "_an"}, {8'h00, an}, {8'h00, ea});
        check({tag, "_seg"}, {9'h000, seg}, {9'h000, es});
        check({tag, "_dp"}, {15'h0000, dp}, {15'h0000, ed});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_dark("rst_async");
        @(posedge clk);
        #1;
        check_dark("rst_hold");
        rst_n = 1'b1;
        n     = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        NUMBER   = 32'h8765_4321;
        dp_in    = 8'h00;
        edit_sel = 1'b0;
        blink_en = 1'b0;
        exp_num  = NUMBER;
        exp_dpin = dp_in;
        exp_blink = 1'b0;
        exp_esel  = 1'b0;

        // Reset hold, release, full frame plus wrap back to digit 0
        repeat (3) @(posedge clk);
        #1;
        check_dark("reset");
        rst_n = 1'b1;
        n     = 0;
        repeat (72) begin
            step();
            check_model("scan");
        end

        // Glyphs, dashes and decimal point
        NUMBER   = 32'hFA98_7650;
        dp_in    = 8'h01;
        exp_num  = NUMBER;
        exp_dpin = dp_in;
        do_reset();
        repeat (64) begin
            step();
            check_model("glyph");
        end

        // Mid-slot NUMBER change only shows at digit 0's next slot
        NUMBER   = 32'h8765_4321;
        dp_in    = 8'h00;
        exp_num  = NUMBER;
        exp_dpin = dp_in;
        do_reset();
        repeat (72) begin
            step();
            if (n == 4) NUMBER[3:0] = 4'h9;
            if (n == 9) exp_num[3:0] = 4'h9;
            check_model("midslot");
        end

        // Blink upper half, then lower half
        NUMBER    = 32'h8765_4321;
        exp_num   = NUMBER;
        blink_en  = 1'b1;
        edit_sel  = 1'b0;
        exp_blink = 1'b1;
        exp_esel  = 1'b0;
        do_reset();
        repeat (160) begin
            step();
            check_model("blink_hi");
        end
        edit_sel = 1'b1;
        exp_esel = 1'b1;
        repeat (160) begin
            step();
            check_model("blink_lo");
        end

        // Async reset during digit 5's SHOW, blink phase must restart visible
        do_reset();
        repeat (44) begin
            step();
            check_model("pre_rst");
        end
        rst_n = 1'b0;
        #1;
        check_dark("mid_rst");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        n        = 0;
        edit_sel = 1'b0;
        exp_esel = 1'b0;
        repeat (80) begin
            step();
            check_model("post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
